// File: rtl/ball_motion_update_pkg.sv
// Shared constants and types for the ball motion datapath and the collision-update stage.
// Direction encoding: 2'b01 steps +1, 2'b11 steps -1; other codes leave a loaded direction unchanged.
package ball_motion_update_pkg;

    localparam int POS_W = 10;
    localparam int SPD_W = 2;

    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b11;

    // Playfield limits shared with the collision stage.
    localparam int DEF_X_INIT = 320;
    localparam int DEF_Y_INIT = 240;
    localparam int DEF_X_MIN  = 20;
    localparam int DEF_X_MAX  = 620;
    localparam int DEF_Y_MIN  = 20;
    localparam int DEF_Y_MAX  = 460;
    localparam int DEF_FRIC_FRAMES = 8;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [1:0]       dir;
    } axis_t;

    // One frame step of a single axis, clamping at a wall and bouncing off it.
    // The comparisons use one extra bit so neither the sum nor the difference wraps.
    function automatic axis_t step_axis(
        input logic [POS_W-1:0] pos,
        input logic [SPD_W-1:0] spd,
        input logic [1:0]       dir,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic [POS_W:0] sum;
        logic [POS_W:0] spd_ext;
        axis_t          res;
        spd_ext = {{(POS_W-1){1'b0}}, spd};
        sum     = {1'b0, pos} + spd_ext;
        res.pos = pos;
        res.dir = dir;
        if (dir == DIR_POS) begin
            if (sum >= {1'b0, hi}) begin
                res.pos = hi;
                res.dir = DIR_NEG;
            end else begin
                res.pos = sum[POS_W-1:0];
            end
        end else if (dir == DIR_NEG) begin
            if ({1'b0, pos} <= ({1'b0, lo} + spd_ext)) begin
                res.pos = lo;
                res.dir = DIR_POS;
            end else begin
                res.pos = pos - spd_ext[POS_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_motion_update_friction_timer.sv
// Frame counter for friction: pulses o_fric_step on the tick that completes FRIC_FRAMES frames.
// The pulse is combinational so the speed decrement lands on the same edge as that tick.
module friction_timer #(
    parameter int FRIC_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_fric_step
);

    localparam int CNT_W = (FRIC_FRAMES > 1) ? $clog2(FRIC_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRIC_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_fric_step = i_tick && (r_cnt == LAST);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_update.sv
// Per-frame ball position/velocity register with wall bounces and optional friction.
// Define BALL_FRICTION_EN to enable the friction timer and speed decay.
module ball_motion_update
    import ball_motion_update_pkg::*;
#(
    parameter int X_INIT      = DEF_X_INIT,
    parameter int Y_INIT      = DEF_Y_INIT,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int FRIC_FRAMES = DEF_FRIC_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             upd_load,
    input  logic [SPD_W-1:0] Vx_UPDATE,
    input  logic [SPD_W-1:0] Vy_UPDATE,
    input  logic [1:0]       Dx_UPDATE,
    input  logic [1:0]       Dy_UPDATE,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic [SPD_W-1:0] Vx_NOW,
    output logic [SPD_W-1:0] Vy_NOW,
    output logic [1:0]       Dx_NOW,
    output logic [1:0]       Dy_NOW,
    output logic             moving
);

    state_t           r_state;
    logic [POS_W-1:0] r_x_pos, r_y_pos;
    logic [SPD_W-1:0] r_vx, r_vy;
    logic [1:0]       r_dx, r_dy;

    axis_t            w_x_next, w_y_next;
    logic [SPD_W-1:0] w_vx_after, w_vy_after;

    assign w_x_next = step_axis(r_x_pos, r_vx, r_dx, POS_W'(X_MIN), POS_W'(X_MAX));
    assign w_y_next = step_axis(r_y_pos, r_vy, r_dy, POS_W'(Y_MIN), POS_W'(Y_MAX));

`ifdef BALL_FRICTION_EN
    logic w_move_tick;
    logic w_fric_step;

    // A load in the same cycle suppresses the frame, so it must not advance the counter either.
    assign w_move_tick = frame_tick && !upd_load && (r_state == MOVE);

    friction_timer #(
        .FRIC_FRAMES (FRIC_FRAMES)
    ) u_friction_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (upd_load),
        .i_tick      (w_move_tick),
        .o_fric_step (w_fric_step)
    );

    assign w_vx_after = (w_fric_step && r_vx != '0) ? r_vx - 1'b1 : r_vx;
    assign w_vy_after = (w_fric_step && r_vy != '0) ? r_vy - 1'b1 : r_vy;
`else
    assign w_vx_after = r_vx;
    assign w_vy_after = r_vy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x_pos <= POS_W'(X_INIT);
            r_y_pos <= POS_W'(Y_INIT);
            r_vx    <= '0;
            r_vy    <= '0;
            r_dx    <= DIR_POS;
            r_dy    <= DIR_POS;
        end else if (upd_load) begin
            r_vx    <= Vx_UPDATE;
            r_vy    <= Vy_UPDATE;
            // Only the two legal codes (low bit set) replace the current direction.
            if (Dx_UPDATE[0]) r_dx <= Dx_UPDATE;
            if (Dy_UPDATE[0]) r_dy <= Dy_UPDATE;
            r_state <= (Vx_UPDATE != '0 || Vy_UPDATE != '0) ? MOVE : IDLE;
        end else if (frame_tick && r_state == MOVE) begin
            r_x_pos <= w_x_next.pos;
            r_dx    <= w_x_next.dir;
            r_y_pos <= w_y_next.pos;
            r_dy    <= w_y_next.dir;
            r_vx    <= w_vx_after;
            r_vy    <= w_vy_after;
            if (w_vx_after == '0 && w_vy_after == '0) r_state <= IDLE;
        end
    end

    assign x_pos  = r_x_pos;
    assign y_pos  = r_y_pos;
    assign Vx_NOW = r_vx;
    assign Vy_NOW = r_vy;
    assign Dx_NOW = r_dx;
    assign Dy_NOW = r_dy;
    assign moving = (r_state == MOVE);

endmodule

// File: tb/tb_ball_motion_update.sv
// Self-checking bench for ball_motion_update: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a plain-arithmetic reference model (honours BALL_FRICTION_EN).
module tb_ball_motion_update;

    localparam int X_MIN = 20, X_MAX = 620, Y_MIN = 20, Y_MAX = 460, FRIC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       upd_load = 1'b0;
    logic [1:0] Vx_UPDATE = '0, Vy_UPDATE = '0, Dx_UPDATE = '0, Dy_UPDATE = '0;
    logic [9:0] x_pos, y_pos;
    logic [1:0] Vx_NOW, Vy_NOW, Dx_NOW, Dy_NOW;
    logic       moving;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    int m_x, m_y, m_vx, m_vy, m_dx, m_dy, m_cnt;

    ball_motion_update dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .upd_load   (upd_load),
        .Vx_UPDATE  (Vx_UPDATE),
        .Vy_UPDATE  (Vy_UPDATE),
        .Dx_UPDATE  (Dx_UPDATE),
        .Dy_UPDATE  (Dy_UPDATE),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .Vx_NOW     (Vx_NOW),
        .Vy_NOW     (Vy_NOW),
        .Dx_NOW     (Dx_NOW),
        .Dy_NOW     (Dy_NOW),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Moves one axis by one frame: bounce off a wall when reaching or passing it.
    task automatic model_axis(inout int p, inout int d, input int v, input int lo, input int hi);
        int n;
        if (d == 1) begin
            n = p + v;
            if (n >= hi) begin p = hi; d = 3; end else p = n;
        end else begin
            n = p - v;
            if (n <= lo) begin p = lo; d = 1; end else p = n;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_x = 320; m_y = 240; m_vx = 0; m_vy = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
        end else if (upd_load) begin
            m_vx = int'(Vx_UPDATE);
            m_vy = int'(Vy_UPDATE);
            if (Dx_UPDATE == 2'b01 || Dx_UPDATE == 2'b11) m_dx = int'(Dx_UPDATE);
            if (Dy_UPDATE == 2'b01 || Dy_UPDATE == 2'b11) m_dy = int'(Dy_UPDATE);
            m_cnt = 0;
        end else if (frame_tick && (m_vx != 0 || m_vy != 0)) begin
            model_axis(m_x, m_dx, m_vx, X_MIN, X_MAX);
            model_axis(m_y, m_dy, m_vy, Y_MIN, Y_MAX);
`ifdef BALL_FRICTION_EN
            if (m_cnt == FRIC - 1) begin
                m_cnt = 0;
                if (m_vx > 0) m_vx--;
                if (m_vy > 0) m_vy--;
            end else begin
                m_cnt++;
            end
`endif
        end
    endtask

    // Applies one cycle of inputs, advances the model, and samples just after the edge.
    task automatic cycle(input logic r, input logic l, input logic t,
                         input logic [1:0] vx, input logic [1:0] vy,
                         input logic [1:0] dx, input logic [1:0] dy);
        @(negedge clk);
        rst = r; upd_load = l; frame_tick = t;
        Vx_UPDATE = vx; Vy_UPDATE = vy; Dx_UPDATE = dx; Dy_UPDATE = dy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".x"},  int'(x_pos),  m_x);
        check({tag, ".y"},  int'(y_pos),  m_y);
        check({tag, ".vx"}, int'(Vx_NOW), m_vx);
        check({tag, ".vy"}, int'(Vy_NOW), m_vy);
        check({tag, ".dx"}, int'(Dx_NOW), m_dx);
        check({tag, ".dy"}, int'(Dy_NOW), m_dy);
        check({tag, ".mv"}, int'(moving), (m_vx != 0 || m_vy != 0) ? 1 : 0);
    endtask

    typedef struct {
        logic       r, l, t;
        logic [1:0] vx, vy, dx, dy;
        int         ex, ey, evx, edx, emv;
    } vec_t;

    vec_t vecs[12];

    task automatic set_vec(input int i, input logic r, input logic l, input logic t,
                           input logic [1:0] vx, input logic [1:0] vy,
                           input logic [1:0] dx, input logic [1:0] dy,
                           input int ex, input int ey, input int evx, input int edx, input int emv);
        vecs[i] = '{r, l, t, vx, vy, dx, dy, ex, ey, evx, edx, emv};
    endtask

    initial begin
        int remaining, n;
        string tag;

        // Hand-computed directed vectors (few enough ticks that friction never fires).
        set_vec(0,  1, 0, 0, 0, 0, 0,     0,     320, 240, 0, 1, 0);
        set_vec(1,  1, 0, 0, 0, 0, 0,     0,     320, 240, 0, 1, 0);
        set_vec(2,  0, 1, 0, 2, 1, 2'b01, 2'b11, 320, 240, 2, 1, 1);
        set_vec(3,  0, 0, 1, 0, 0, 0,     0,     322, 239, 2, 1, 1);
        set_vec(4,  0, 0, 1, 0, 0, 0,     0,     324, 238, 2, 1, 1);
        set_vec(5,  0, 0, 1, 0, 0, 0,     0,     326, 237, 2, 1, 1);
        set_vec(6,  0, 1, 1, 3, 0, 2'b10, 2'b00, 326, 237, 3, 1, 1);
        set_vec(7,  0, 0, 1, 0, 0, 0,     0,     329, 237, 3, 1, 1);
        set_vec(8,  1, 1, 1, 2, 2, 2'b11, 2'b11, 320, 240, 0, 1, 0);
        set_vec(9,  0, 0, 1, 0, 0, 0,     0,     320, 240, 0, 1, 0);
        set_vec(10, 0, 1, 0, 0, 0, 2'b11, 2'b01, 320, 240, 0, 3, 0);
        set_vec(11, 0, 0, 1, 0, 0, 0,     0,     320, 240, 0, 3, 0);

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].r, vecs[i].l, vecs[i].t, vecs[i].vx, vecs[i].vy, vecs[i].dx, vecs[i].dy);
            tag = $sformatf("vec%0d", i);
            check({tag, ".x"},  int'(x_pos),  vecs[i].ex);
            check({tag, ".y"},  int'(y_pos),  vecs[i].ey);
            check({tag, ".vx"}, int'(Vx_NOW), vecs[i].evx);
            check({tag, ".dx"}, int'(Dx_NOW), vecs[i].edx);
            check({tag, ".mv"}, int'(moving), vecs[i].emv);
        end

        // Friction: load Vx=1 only, then 8 ticks, then a 9th.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 2'b01, 2'b01);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 0, 0);
`ifdef BALL_FRICTION_EN
        check("fric8.x",  int'(x_pos),  328);
        check("fric8.vx", int'(Vx_NOW), 0);
        check("fric8.mv", int'(moving), 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("fric9.x",  int'(x_pos),  328);
`else
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("fric9.x",  int'(x_pos),  329);
        check("fric9.vx", int'(Vx_NOW), 1);
        check("fric9.mv", int'(moving), 1);
`endif

        // Walk to x=619 at speed 1, reloading before friction could fire, then hit the right wall.
        cycle(1, 0, 0, 0, 0, 0, 0);
        remaining = 299;
        while (remaining > 0) begin
            cycle(0, 1, 0, 1, 0, 2'b01, 2'b01);
            n = (remaining < 7) ? remaining : 7;
            for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0, 0, 0);
            remaining -= n;
        end
        check("wall.pre_x", int'(x_pos), 619);
        cycle(0, 1, 0, 3, 0, 2'b01, 2'b01);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("wall.hit_x",  int'(x_pos),  620);
        check("wall.hit_dx", int'(Dx_NOW), 3);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("wall.back_x", int'(x_pos),  617);

        // Randomized traffic against the reference model.
        cycle(1, 0, 0, 0, 0, 0, 0);
        compare_model("rnd_reset");
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 1),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            compare_model($sformatf("rnd%0d", i));
        end

        @(negedge clk);
        rst = 1'b0; upd_load = 1'b0; frame_tick = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
